multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Control FSM for the multicycle RV32I core (lw, sw, R-type, addi, beq, jal); replaces single-cycle decoding.
//  Sequences shared ALU, unified instr/data memory and regfile over 3-5 cycles per instruction.
//  Memory handshake via mem_req/mem_ready; counts retired instructions; flags unsupported opcodes.
// PARAMETERS
//  MEM_HANDSHAKE  1   1: wait on mem_ready; 0: mem_ready ignored, treated as 1 (single-cycle memory)
//  CNT_W          32  width of instret counter
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      synchronous, active-high
//  op           in   7      instr[6:0] from IR; valid from DECODE onward
//  zero         in   1      ALU zero flag
//  mem_ready    in   1      memory completes current access this cycle
//  mem_req      out  1      memory access requested (FETCH, MEMREAD, MEMWRITE)
//  pc_write     out  1      PC register load enable
//  adr_src      out  1      memory address mux: 0=PC, 1=ALUOut
//  ir_write     out  1      IR/OldPC load enable
//  mem_write    out  1      memory write strobe
//  reg_write    out  1      regfile write enable
//  result_src   out  2      00=ALUOut, 01=Data, 10=ALUResult
//  alu_src_a    out  2      00=PC, 01=OldPC, 10=RD1
//  alu_src_b    out  2      00=RD2/WriteData, 01=ImmExt, 10=constant 4
//  alu_op       out  2      00=add, 01=sub (branch), 10=funct-decoded
//  imm_src      out  2      combinational from op: lw/addi 00, sw 01, beq 10, jal 11, other 00
//  illegal_op   out  1      one-cycle pulse in DECODE for unsupported op
//  state        out  4      current state encoding (debug)
//  instret      out  CNT_W  retired-instruction count
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 MEMADR=2 MEMREAD=3 MEMWB=4 MEMWRITE=5 EXECR=6 ALUWB=7 EXECI=8 JAL=9 BEQ=10.
//  Reset: next state FETCH, instret<=0. While reset=1 all strobes (mem_req, pc_write, ir_write, mem_write,
//   reg_write, illegal_op) forced 0; mux selects follow FETCH values. Reset overrides any in-flight state.
//  Outputs are Moore (decode of state); exceptions: pc_write uses zero, strobes gated by mem_ready.
//  Unlisted outputs are 0 in every state. Encodings 11-15: all outputs 0, next state FETCH.
//  FETCH: mem_req=1 adr_src=0 alu_src_a=00 alu_src_b=10 alu_op=00 result_src=10;
//   ir_write=pc_write=mem_ready; hold FETCH while !mem_ready, else -> DECODE.
//  DECODE: alu_src_a=01 alu_src_b=01 alu_op=00 (branch target). Next by op:
//   0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1101111 -> JAL; 1100011 -> BEQ;
//   any other -> FETCH with illegal_op=1 (no writes, not counted).
//  MEMADR: alu_src_a=10 alu_src_b=01 alu_op=00; lw -> MEMREAD, sw -> MEMWRITE.
//  MEMREAD: mem_req=1 adr_src=1; hold while !mem_ready, else -> MEMWB.
//  MEMWB: result_src=01 reg_write=1 -> FETCH.
//  MEMWRITE: mem_req=1 adr_src=1 mem_write=1 (held for entire wait); hold while !mem_ready, else -> FETCH.
//  EXECR: alu_src_a=10 alu_src_b=00 alu_op=10 -> ALUWB.  EXECI: alu_src_a=10 alu_src_b=01 alu_op=10 -> ALUWB.
//  ALUWB: result_src=00 reg_write=1 -> FETCH.
//  JAL: alu_src_a=01 alu_src_b=10 alu_op=00 result_src=00 pc_write=1 -> ALUWB.
//  BEQ: alu_src_a=10 alu_src_b=00 alu_op=01 result_src=00 pc_write=zero -> FETCH.
//  Latency (zero wait): lw 5, sw 4, R/addi 4, jal 4, beq 3 cycles; each wait cycle adds 1.
//  instret: +1 on the last cycle of MEMWB, ALUWB, BEQ, and of MEMWRITE when mem_ready=1;
//   wraps from all-ones to 0.
// TESTING
//  T1 reset, op=0000011, mem_ready=1 -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB,FETCH; reg_write only in MEMWB; instret=1
//  T2 FETCH with mem_ready=0 for 3 cycles -> state stays 0 for 4 cycles; ir_write/pc_write high only in 4th
//  T3 op=1100011, zero=1 then zero=0 -> BEQ cycle pc_write=1 then 0; alu_op=01; both take 3 cycles; instret+=2
//  T4 op=0100011, mem_ready low 2 cycles in MEMWRITE -> mem_write=1 for 3 cycles, reg_write never 1; instret+1
//  T5 op=1111111 -> illegal_op=1 for exactly 1 cycle in DECODE, next state FETCH, instret unchanged
//  T6 reset=1 during MEMWRITE -> mem_write=0 that cycle, state=FETCH next cycle; op=1101111 -> JAL then ALUWB

Source files
------------

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle RV32I controller and its datapath.
// The controller drives through the master modport. The datapath or bench uses the slave modport.
interface multicycle_control_fsm_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       op;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             pc_write;
  logic             adr_src;
  logic             ir_write;
  logic             mem_write;
  logic             reg_write;
  logic [1:0]       result_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       imm_src;
  logic             illegal_op;
  logic [3:0]       state;
  logic [CNT_W-1:0] instret;

  modport master (
    input  op, zero, mem_ready,
    output mem_req, pc_write, adr_src, ir_write, mem_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal_op,
           state, instret
  );

  modport slave (
    output op, zero, mem_ready,
    input  mem_req, pc_write, adr_src, ir_write, mem_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal_op,
           state, instret
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control FSM for lw, sw, R-type, addi, beq and jal.
// It sequences the shared ALU, the unified memory and the regfile, and counts retired instructions.
module multicycle_control_fsm #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    st_fetch    = 4'd0,
    st_decode   = 4'd1,
    st_memadr   = 4'd2,
    st_memread  = 4'd3,
    st_memwb    = 4'd4,
    st_memwrite = 4'd5,
    st_execr    = 4'd6,
    st_aluwb    = 4'd7,
    st_execi    = 4'd8,
    st_jal      = 4'd9,
    st_beq      = 4'd10
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       fetch_wr;
    logic       mem_write;
    logic       reg_write;
    logic       pc_jump;
    logic       pc_branch;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctl_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // Moore control word for each state. Unreachable encodings decode to all zeros.
  function automatic ctl_t ctl_of(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      st_fetch:    begin c.mem_req = 1'b1; c.fetch_wr = 1'b1;
                         c.alu_src_b = 2'b10; c.result_src = 2'b10; end
      st_decode:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      st_memadr:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      st_memread:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
      st_memwb:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      st_memwrite: begin c.mem_req = 1'b1; c.adr_src = 1'b1; c.mem_write = 1'b1; end
      st_execr:    begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
      st_execi:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      st_aluwb:    c.reg_write = 1'b1;
      st_jal:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_jump = 1'b1; end
      st_beq:      begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.pc_branch = 1'b1; end
      default:     ;
    endcase
    return c;
  endfunction

  function automatic state_t next_of(input state_t s, input logic [6:0] op, input logic rdy);
    state_t n;
    n = st_fetch;
    case (s)
      st_fetch:    n = rdy ? st_decode : st_fetch;
      st_decode:   case (op)
                     OP_LW, OP_SW: n = st_memadr;
                     OP_R:         n = st_execr;
                     OP_I:         n = st_execi;
                     OP_JAL:       n = st_jal;
                     OP_BEQ:       n = st_beq;
                     default:      n = st_fetch;
                   endcase
      st_memadr:   n = (op == OP_SW) ? st_memwrite : st_memread;
      st_memread:  n = rdy ? st_memwb : st_memread;
      st_memwrite: n = rdy ? st_fetch : st_memwrite;
      st_execr,
      st_execi,
      st_jal:      n = st_aluwb;
      default:     n = st_fetch;
    endcase
    return n;
  endfunction

  state_t           state;
  state_t           nxt;
  ctl_t             ctl;
  ctl_t             sel;
  logic [CNT_W-1:0] instret;
  logic             rdy;
  logic             retire;
  logic             legal;

  assign rdy    = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
  assign nxt    = next_of(state, bus.op, rdy);
  assign legal  = bus.op inside {OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ};
  assign retire = (state == st_memwb) || (state == st_aluwb) || (state == st_beq) ||
                  ((state == st_memwrite) && rdy);

  // The control word is registered alongside the state it belongs to, so it always matches the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= st_fetch;
      ctl     <= ctl_of(st_fetch);
      instret <= '0;
    end else begin
      state <= nxt;
      ctl   <= ctl_of(nxt);
      if (retire)
        instret <= instret + CNT_W'(1);
    end
  end

  // Reset overrides whatever is in flight: the strobes are killed and the muxes show the FETCH selects.
  assign sel = reset ? ctl_of(st_fetch) : ctl;

  assign bus.mem_req    = sel.mem_req & ~reset;
  assign bus.mem_write  = sel.mem_write & ~reset;
  assign bus.reg_write  = sel.reg_write & ~reset;
  assign bus.ir_write   = sel.fetch_wr & rdy & ~reset;
  assign bus.pc_write   = ((sel.fetch_wr & rdy) | sel.pc_jump | (sel.pc_branch & bus.zero)) & ~reset;
  assign bus.adr_src    = sel.adr_src;
  assign bus.result_src = sel.result_src;
  assign bus.alu_src_a  = sel.alu_src_a;
  assign bus.alu_src_b  = sel.alu_src_b;
  assign bus.alu_op     = sel.alu_op;
  assign bus.illegal_op = (state == st_decode) & ~legal & ~reset;
  assign bus.state      = state;
  assign bus.instret    = instret;

  always_comb begin
    bus.imm_src = 2'b00;
    case (bus.op)
      OP_SW:   bus.imm_src = 2'b01;
      OP_BEQ:  bus.imm_src = 2'b10;
      OP_JAL:  bus.imm_src = 2'b11;
      default: bus.imm_src = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for the multicycle control FSM. Each cycle pushes the expected state, strobes, alu_op and instret to a scoreboard.
// Each test task then pops those entries and compares them against the captured DUT outputs.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic [3:0]  st;
    logic [5:0]  str;
    logic [1:0]  aop;
    logic [31:0] ret;
  } snap_t;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] AI = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011, BAD = 7'b1111111;
  // Strobe patterns, in the order {mem_req, ir_write, pc_write, mem_write, reg_write, illegal_op}.
  localparam logic [5:0] FET = 6'b111000, REQ = 6'b100000, NON = 6'b000000;
  localparam logic [5:0] WB  = 6'b000010, MW  = 6'b100100, PCW = 6'b001000, ILL = 6'b000001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  snap_t sb[$];
  snap_t obsq[$];
  logic [31:0] ret = 32'd0;
  int checks = 0;
  int passed = 0;

  multicycle_control_fsm_if #(.CNT_W(32)) bus ();

  multicycle_control_fsm #(.MEM_HANDSHAKE(1'b1), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic rst, input logic mr, input logic z, input logic [6:0] o,
                               input logic [3:0] est, input logic [5:0] estr, input logic [1:0] eop,
                               input bit retire);
    @(negedge clk);
    reset = rst;
    bus.mem_ready = mr;
    bus.zero = z;
    bus.op = o;
    sb.push_back('{est, estr, eop, ret});
    if (retire) ret = ret + 32'd1;
    #1;
    obsq.push_back('{bus.state, {bus.mem_req, bus.ir_write, bus.pc_write, bus.mem_write,
                     bus.reg_write, bus.illegal_op}, bus.alu_op, bus.instret});
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    bus.zero = 1'b0;
    bus.op = LW;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.state !== 4'd0) $display("[TB] FAIL reset_state: got %0d want 0", bus.state);
    else passed++;
    checks++;
    if ({bus.mem_req, bus.ir_write, bus.pc_write, bus.mem_write, bus.reg_write, bus.illegal_op} !== NON)
      $display("[TB] FAIL reset_strobes: got %b want %b",
               {bus.mem_req, bus.ir_write, bus.pc_write, bus.mem_write, bus.reg_write, bus.illegal_op}, NON);
    else passed++;
    checks++;
    if ({bus.adr_src, bus.alu_src_a, bus.alu_src_b, bus.result_src} !== 7'b0001010)
      $display("[TB] FAIL reset_selects: got %b want 0001010",
               {bus.adr_src, bus.alu_src_a, bus.alu_src_b, bus.result_src});
    else passed++;
    checks++;
    if (bus.instret !== 32'd0) $display("[TB] FAIL reset_instret: got %0d want 0", bus.instret);
    else passed++;
  endtask

  task automatic test_lw();
    snap_t e, o;
    applyStimulus(0, 1, 0, LW, 4'd0, FET, 2'b00, 0);
    applyStimulus(0, 1, 0, LW, 4'd1, NON, 2'b00, 0);
    applyStimulus(0, 1, 0, LW, 4'd2, NON, 2'b00, 0);
    applyStimulus(0, 1, 0, LW, 4'd3, REQ, 2'b00, 0);
    applyStimulus(0, 1, 0, LW, 4'd4, WB,  2'b00, 1);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); o = obsq.pop_front(); checks++;
      if (o !== e) $display("[TB] FAIL lw cyc%0d: got %h want %h", i, o, e);
      else passed++;
    end
  endtask

  task automatic test_fetch_wait();
    snap_t e, o;
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, RT, 4'd0, REQ, 2'b00, 0);
    applyStimulus(0, 1, 0, RT, 4'd0, FET, 2'b00, 0);
    applyStimulus(0, 1, 0, RT, 4'd1, NON, 2'b00, 0);
    applyStimulus(0, 1, 0, RT, 4'd6, NON, 2'b10, 0);
    applyStimulus(0, 1, 0, RT, 4'd7, WB,  2'b00, 1);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); o = obsq.pop_front(); checks++;
      if (o !== e) $display("[TB] FAIL fetch_wait cyc%0d: got %h want %h", i, o, e);
      else passed++;
    end
  endtask

  task automatic test_beq();
    snap_t e, o;
    applyStimulus(0, 1, 1, BQ, 4'd0,  FET, 2'b00, 0);
    applyStimulus(0, 1, 1, BQ, 4'd1,  NON, 2'b00, 0);
    applyStimulus(0, 1, 1, BQ, 4'd10, PCW, 2'b01, 1);
    applyStimulus(0, 1, 0, BQ, 4'd0,  FET, 2'b00, 0);
    applyStimulus(0, 1, 0, BQ, 4'd1,  NON, 2'b00, 0);
    applyStimulus(0, 1, 0, BQ, 4'd10, NON, 2'b01, 1);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); o = obsq.pop_front(); checks++;
      if (o !== e) $display("[TB] FAIL beq cyc%0d: got %h want %h", i, o, e);
      else passed++;
    end
  endtask

  task automatic test_sw_wait();
    snap_t e, o;
    applyStimulus(0, 1, 0, SW, 4'd0, FET, 2'b00, 0);
    applyStimulus(0, 1, 0, SW, 4'd1, NON, 2'b00, 0);
    applyStimulus(0, 1, 0, SW, 4'd2, NON, 2'b00, 0);
    applyStimulus(0, 0, 0, SW, 4'd5, MW,  2'b00, 0);
    applyStimulus(0, 0, 0, SW, 4'd5, MW,  2'b00, 0);
    applyStimulus(0, 1, 0, SW, 4'd5, MW,  2'b00, 1);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); o = obsq.pop_front(); checks++;
      if (o !== e) $display("[TB] FAIL sw_wait cyc%0d: got %h want %h", i, o, e);
      else passed++;
    end
  endtask

  task automatic test_illegal();
    snap_t e, o;
    applyStimulus(0, 1, 0, BAD, 4'd0, FET, 2'b00, 0);
    applyStimulus(0, 1, 0, BAD, 4'd1, ILL, 2'b00, 0);
    applyStimulus(0, 0, 0, BAD, 4'd0, REQ, 2'b00, 0);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); o = obsq.pop_front(); checks++;
      if (o !== e) $display("[TB] FAIL illegal cyc%0d: got %h want %h", i, o, e);
      else passed++;
    end
  endtask

  task automatic test_imm_src();
    logic [6:0] ops [5] = '{LW, SW, BQ, JL, AI};
    logic [1:0] want [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      bus.op = ops[k];
      #1;
      checks++;
      if (bus.imm_src !== want[k] || bus.state !== 4'd0)
        $display("[TB] FAIL imm_src op=%b: got imm=%b st=%0d want imm=%b st=0",
                 ops[k], bus.imm_src, bus.state, want[k]);
      else passed++;
    end
  endtask

  task automatic test_reset_midflight();
    snap_t e, o;
    applyStimulus(0, 1, 0, SW, 4'd0, FET, 2'b00, 0);
    applyStimulus(0, 1, 0, SW, 4'd1, NON, 2'b00, 0);
    applyStimulus(0, 1, 0, SW, 4'd2, NON, 2'b00, 0);
    applyStimulus(0, 0, 0, SW, 4'd5, MW,  2'b00, 0);
    applyStimulus(1, 0, 0, SW, 4'd5, NON, 2'b00, 0);
    ret = 32'd0;
    applyStimulus(0, 1, 0, JL, 4'd0, FET, 2'b00, 0);
    applyStimulus(0, 1, 0, JL, 4'd1, NON, 2'b00, 0);
    applyStimulus(0, 1, 0, JL, 4'd9, PCW, 2'b00, 0);
    applyStimulus(0, 1, 0, JL, 4'd7, WB,  2'b00, 1);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); o = obsq.pop_front(); checks++;
      if (o !== e) $display("[TB] FAIL reset_midflight cyc%0d: got %h want %h", i, o, e);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    snap_t e, o;
    applyStimulus(0, 1, 0, AI, 4'd0, FET, 2'b00, 0);
    applyStimulus(0, 1, 0, AI, 4'd1, NON, 2'b00, 0);
    applyStimulus(0, 1, 0, AI, 4'd8, NON, 2'b10, 0);
    applyStimulus(0, 1, 0, AI, 4'd7, WB,  2'b00, 1);
    applyStimulus(0, 1, 0, LW, 4'd0, FET, 2'b00, 0);
    applyStimulus(0, 1, 0, LW, 4'd1, NON, 2'b00, 0);
    applyStimulus(0, 1, 0, LW, 4'd2, NON, 2'b00, 0);
    applyStimulus(0, 0, 0, LW, 4'd3, REQ, 2'b00, 0);
    applyStimulus(0, 1, 0, LW, 4'd3, REQ, 2'b00, 0);
    applyStimulus(0, 1, 0, LW, 4'd4, WB,  2'b00, 1);
    applyStimulus(0, 0, 0, LW, 4'd0, REQ, 2'b00, 0);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); o = obsq.pop_front(); checks++;
      if (o !== e) $display("[TB] FAIL back_to_back cyc%0d: got %h want %h", i, o, e);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_fetch_wait();
    test_beq();
    test_sw_wait();
    test_illegal();
    test_imm_src();
    test_reset_midflight();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
